multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Multicycle control unit, successor to the single-cycle main decoder. A Moore FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over several cycles. Memory accesses use a memReady handshake, and a retired-instruction counter is parametrised. Sits between the instruction register/ALU-zero flag and the shared-memory multicycle datapath.

Parameters:
OP_WIDTH, 5, opcode width.
ALUCTRL_WIDTH, 4, aluControl width.
CNT_WIDTH, 16, retired-instruction counter width.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high.
opCode  input  OP_WIDTH  IR opcode field; valid from DECODE onward.
zero  input  1  ALU zero flag.
memReady  input  1  memory completes the current read/write this cycle.
memRead  output  1  memory read request.
memWrite  output  1  memory write request.
iorD  output  1  address select: 0=PC, 1=ALUOut.
irWrite  output  1  load instruction register.
pcWrite  output  1  load PC.
pcSrc  output  2  00=ALU result, 01=ALUOut, 10=jump target.
aluSrcA  output  1  0=PC, 1=regA.
aluSrcB  output  2  00=regB, 01=const 4, 10=imm, 11=imm<<2.
aluControl  output  ALUCTRL_WIDTH  ALU operation (package encodings).
regWrite  output  1  register file write.
regDst  output  1  1=rd, 0=rt.
memToReg  output  1  1=MDR, 0=ALUOut.
instrDone  output  1  one-cycle pulse per retired instruction.
retired  output  CNT_WIDTH  retired-instruction count.
halted  output  1  high in HALT state.

Behaviour:
- reset high: state=FETCH, retired=0, opcode latch=0; every output forced to 0 while reset is held, regardless of state.
- Outputs are a Moore decode of the state, except pcWrite/irWrite (qualified by memReady or zero).
- Unlisted outputs are 0; aluControl=ADD unless stated.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, pcSrc=00. Stay until memReady. On memReady, irWrite=1 and pcWrite=1, then go to DECODE.
- DECODE: latch opCode internally; aluSrcA=0, aluSrcB=11 (branch target into ALUOut). Next state by opcode:
  - R-ALU -> EXEC_R
  - ADDI -> EXEC_I
  - LW/SW -> MEM_ADDR
  - BEQ -> BRANCH
  - J -> JUMP
  - HALT -> HALT
  - illegal -> see Optional Feature
- EXEC_R: aluSrcA=1, aluSrcB=00, aluControl from latched op -> ALU_WB.
- EXEC_I: aluSrcA=1, aluSrcB=10, ADD -> ALU_WB.
- ALU_WB: regWrite=1, regDst=(op is R-ALU), memToReg=0, instrDone=1 -> FETCH.
- MEM_ADDR: aluSrcA=1, aluSrcB=10, ADD -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: memRead=1, iorD=1; wait for memReady -> MEM_WB.
- MEM_WB: regWrite=1, regDst=0, memToReg=1, instrDone=1 -> FETCH.
- MEM_WR: memWrite=1, iorD=1; wait for memReady. On memReady, instrDone=1 -> FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, SUB, pcSrc=01, pcWrite=zero, instrDone=1 -> FETCH.
- JUMP: pcSrc=10, pcWrite=1, instrDone=1 -> FETCH.
- HALT: halted=1, terminal; exit only by reset.
- Latency with memReady tied high: R/ADDI=4, LW=5, SW=4, BEQ=3, J=3 cycles. Each wait cycle adds one.
- retired increments on every instrDone and wraps modulo 2^CNT_WIDTH.
- memReady outside FETCH/MEM_RD/MEM_WR is ignored. memRead and memWrite are never both 1.
- Reset asserted mid-instruction aborts it: no instrDone, counter cleared.

Optional Feature:
MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: illegal opcode in DECODE -> TRAP state. Adds output illegalOp (1), high only in TRAP. TRAP is terminal until reset; no instrDone.
- Undefined: illegal opcode is a NOP. DECODE -> FETCH with instrDone=1 and retired incremented.

Decomposition:
- Package multicycle_pkg:
  - state enum
  - opcode constants: ADD=00000, SUB=00001, AND=00010, OR=00011, SLT=00100, ADDI=00101, LW=00110, SW=00111, BEQ=01000, J=01001, HALT=11111
  - aluControl constants: ADD=0000, SUB=0001, AND=0010, OR=0011, SLT=0100
  - pcSrc/aluSrcB select constants
- One sub-module, multicycle_aludec: combinational latched-op -> aluControl map.

Test Plan:
1. Reset held 3 cycles, then released with memReady=1 -> all outputs 0 during reset; FETCH with memRead=1 on the first cycle after release.
2. Opcode ADD (00000), memReady=1 -> instrDone on cycle 4; ALU_WB shows regWrite=1, regDst=1; retired=1.
3. LW with memReady held low 2 cycles in MEM_RD -> instrDone on cycle 7; memRead=1 and iorD=1 throughout the wait; memToReg=1 in MEM_WB.
4. BEQ with zero=1, then with zero=0 -> pcWrite=1 vs 0 in BRANCH, pcSrc=01; 3 cycles each.
5. Opcode 10101, both macro builds -> defined: TRAP, illegalOp=1 forever, retired unchanged; undefined: back to FETCH after 2 cycles, retired+1.
6. CNT_WIDTH=2, five J instructions, then HALT -> retired wraps 3->0->1; halted=1 stays; reset asserted in HALT returns to FETCH with retired=0.

Source files
------------

// File: rtl/multicycle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_pkg
// Description : Shared types and constants for the multicycle control unit:
//               FSM state encoding, opcode map, ALU operation encodings and
//               datapath mux select values.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_pkg;

    // Opcode field width that the constant map below is written against.
    localparam int c_OP_W = 5;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_HALT     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    // Opcodes
    localparam logic [c_OP_W-1:0] c_OP_ADD  = 5'b00000;
    localparam logic [c_OP_W-1:0] c_OP_SUB  = 5'b00001;
    localparam logic [c_OP_W-1:0] c_OP_AND  = 5'b00010;
    localparam logic [c_OP_W-1:0] c_OP_OR   = 5'b00011;
    localparam logic [c_OP_W-1:0] c_OP_SLT  = 5'b00100;
    localparam logic [c_OP_W-1:0] c_OP_ADDI = 5'b00101;
    localparam logic [c_OP_W-1:0] c_OP_LW   = 5'b00110;
    localparam logic [c_OP_W-1:0] c_OP_SW   = 5'b00111;
    localparam logic [c_OP_W-1:0] c_OP_BEQ  = 5'b01000;
    localparam logic [c_OP_W-1:0] c_OP_J    = 5'b01001;
    localparam logic [c_OP_W-1:0] c_OP_HALT = 5'b11111;

    // ALU operations
    localparam logic [3:0] c_ALU_ADD = 4'b0000;
    localparam logic [3:0] c_ALU_SUB = 4'b0001;
    localparam logic [3:0] c_ALU_AND = 4'b0010;
    localparam logic [3:0] c_ALU_OR  = 4'b0011;
    localparam logic [3:0] c_ALU_SLT = 4'b0100;

    // PC source select
    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] c_SRCB_REGB  = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
    localparam logic [1:0] c_SRCB_IMM   = 2'b10;
    localparam logic [1:0] c_SRCB_IMMSH = 2'b11;

    // Register-register ALU instructions (write back to rd).
    function automatic logic isRAlu(input logic [c_OP_W-1:0] op);
        return (op == c_OP_ADD) || (op == c_OP_SUB) || (op == c_OP_AND) ||
               (op == c_OP_OR)  || (op == c_OP_SLT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_aludec.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_aludec
// Description : Combinational map from the latched opcode to the ALU
//               operation used in the EXEC_R state. Non-R opcodes map to ADD.
// Ports       : op         - latched opcode
//               aluControl - ALU operation encoding
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_aludec
    import multicycle_pkg::*;
#(
    parameter int ALUCTRL_WIDTH = 4
) (
    input  logic [c_OP_W-1:0]        op,
    output logic [ALUCTRL_WIDTH-1:0] aluControl
);

    always_comb begin
        aluControl = ALUCTRL_WIDTH'(c_ALU_ADD);
        case (op)
            c_OP_SUB: aluControl = ALUCTRL_WIDTH'(c_ALU_SUB);
            c_OP_AND: aluControl = ALUCTRL_WIDTH'(c_ALU_AND);
            c_OP_OR:  aluControl = ALUCTRL_WIDTH'(c_ALU_OR);
            c_OP_SLT: aluControl = ALUCTRL_WIDTH'(c_ALU_SLT);
            default:  aluControl = ALUCTRL_WIDTH'(c_ALU_ADD);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multicycle control unit. Moore FSM sequencing each
//               instruction through fetch / decode / execute / memory /
//               write-back, with a memReady handshake on memory states and a
//               wrapping retired-instruction counter.
// Ports       : clk, reset (async, active-high)
//               opCode, zero, memReady            - status inputs
//               memRead, memWrite, iorD, irWrite,
//               pcWrite, pcSrc, aluSrcA, aluSrcB,
//               aluControl, regWrite, regDst,
//               memToReg                          - datapath controls
//               instrDone, retired, halted        - retirement status
//               illegalOp                         - only with the macro below
// Macro       : MULTICYCLE_ILLEGAL_TRAP_EN - illegal opcodes enter a terminal
//               TRAP state instead of retiring as a NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int OP_WIDTH      = 5,
    parameter int ALUCTRL_WIDTH = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [OP_WIDTH-1:0]      opCode,
    input  logic                     zero,
    input  logic                     memReady,
    output logic                     memRead,
    output logic                     memWrite,
    output logic                     iorD,
    output logic                     irWrite,
    output logic                     pcWrite,
    output logic [1:0]               pcSrc,
    output logic                     aluSrcA,
    output logic [1:0]               aluSrcB,
    output logic [ALUCTRL_WIDTH-1:0] aluControl,
    output logic                     regWrite,
    output logic                     regDst,
    output logic                     memToReg,
    output logic                     instrDone,
    output logic [CNT_WIDTH-1:0]     retired,
    output logic                     halted
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    ,
    output logic                     illegalOp
`endif
);

    state_t                     r_state;
    logic [c_OP_W-1:0]          r_opLatch;
    logic [CNT_WIDTH-1:0]       r_retired;

    state_t                     w_nextState;
    logic                       w_instrDone;
    logic [c_OP_W-1:0]          w_opNow;
    logic [ALUCTRL_WIDTH-1:0]   w_aluR;

    assign w_opNow = c_OP_W'(opCode);

    multicycle_aludec #(
        .ALUCTRL_WIDTH (ALUCTRL_WIDTH)
    ) u_aludec (
        .op         (r_opLatch),
        .aluControl (w_aluR)
    );

    // Next state and retirement. DECODE dispatches on the live opcode since
    // the latch only captures it at the end of that cycle.
    always_comb begin
        w_nextState = r_state;
        w_instrDone = 1'b0;
        case (r_state)
            S_FETCH:    if (memReady) w_nextState = S_DECODE;
            S_DECODE: begin
                if (isRAlu(w_opNow)) begin
                    w_nextState = S_EXEC_R;
                end else begin
                    case (w_opNow)
                        c_OP_ADDI:       w_nextState = S_EXEC_I;
                        c_OP_LW, c_OP_SW: w_nextState = S_MEM_ADDR;
                        c_OP_BEQ:        w_nextState = S_BRANCH;
                        c_OP_J:          w_nextState = S_JUMP;
                        c_OP_HALT:       w_nextState = S_HALT;
                        default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                            w_nextState = S_TRAP;
`else
                            // Illegal opcode retires as a NOP.
                            w_nextState = S_FETCH;
                            w_instrDone = 1'b1;
`endif
                        end
                    endcase
                end
            end
            S_EXEC_R, S_EXEC_I: w_nextState = S_ALU_WB;
            S_ALU_WB: begin
                w_nextState = S_FETCH;
                w_instrDone = 1'b1;
            end
            S_MEM_ADDR: w_nextState = (r_opLatch == c_OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (memReady) w_nextState = S_MEM_WB;
            S_MEM_WB: begin
                w_nextState = S_FETCH;
                w_instrDone = 1'b1;
            end
            S_MEM_WR: begin
                if (memReady) begin
                    w_nextState = S_FETCH;
                    w_instrDone = 1'b1;
                end
            end
            S_BRANCH, S_JUMP: begin
                w_nextState = S_FETCH;
                w_instrDone = 1'b1;
            end
            S_HALT:     w_nextState = S_HALT;
            S_TRAP:     w_nextState = S_TRAP;
            default:    w_nextState = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_opLatch <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_DECODE) begin
                r_opLatch <= w_opNow;
            end
            if (w_instrDone) begin
                r_retired <= r_retired + CNT_WIDTH'(1);
            end
        end
    end

    // Output decode of the registered state. The state register sits in
    // FETCH during reset, so everything is explicitly masked by reset.
    always_comb begin
        memRead    = 1'b0;
        memWrite   = 1'b0;
        iorD       = 1'b0;
        irWrite    = 1'b0;
        pcWrite    = 1'b0;
        pcSrc      = c_PCSRC_ALU;
        aluSrcA    = 1'b0;
        aluSrcB    = c_SRCB_REGB;
        aluControl = ALUCTRL_WIDTH'(c_ALU_ADD);
        regWrite   = 1'b0;
        regDst     = 1'b0;
        memToReg   = 1'b0;
        halted     = 1'b0;
        case (r_state)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = c_SRCB_FOUR;
                irWrite = memReady;
                pcWrite = memReady;
            end
            S_DECODE:   aluSrcB = c_SRCB_IMMSH;
            S_EXEC_R: begin
                aluSrcA    = 1'b1;
                aluControl = w_aluR;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                aluSrcA = 1'b1;
                aluSrcB = c_SRCB_IMM;
            end
            S_ALU_WB: begin
                regWrite = 1'b1;
                regDst   = isRAlu(r_opLatch);
            end
            S_MEM_RD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            S_MEM_WB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            S_MEM_WR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA    = 1'b1;
                aluControl = ALUCTRL_WIDTH'(c_ALU_SUB);
                pcSrc      = c_PCSRC_ALUOUT;
                pcWrite    = zero;
            end
            S_JUMP: begin
                pcSrc   = c_PCSRC_JUMP;
                pcWrite = 1'b1;
            end
            S_HALT:     halted = 1'b1;
            default: ;
        endcase
        if (reset) begin
            memRead    = 1'b0;
            memWrite   = 1'b0;
            iorD       = 1'b0;
            irWrite    = 1'b0;
            pcWrite    = 1'b0;
            pcSrc      = 2'b00;
            aluSrcA    = 1'b0;
            aluSrcB    = 2'b00;
            aluControl = '0;
            regWrite   = 1'b0;
            regDst     = 1'b0;
            memToReg   = 1'b0;
            halted     = 1'b0;
        end
    end

    assign instrDone = w_instrDone & ~reset;
    assign retired   = r_retired;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    assign illegalOp = (r_state == S_TRAP) & ~reset;
`endif

endmodule
`default_nettype wire
